// File: rtl/fetch_unit.sv
// Purpose : RV32I instruction fetch stage; owns the PC, reads imem over req/ack,
//           hands instructions to decode through an output register plus a one-entry skid.
// Latency : two edges from reset release to the first valid instruction; one instruction
//           per cycle with zero-wait memory. Backpressure: decode_stall freezes the output;
//           one in-flight response parks in the skid and the request drops (HOLD) until it drains.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req/imem_addr          word read request; held stable until imem_ack
//   imem_ack/imem_rdata         read completion (may be in the request cycle)
//   decode_enable/i_din/fetch_pc  instruction handed to decode, with its PC
//   decode_stall                decode cannot consume this cycle
//   redirect_valid/redirect_pc  one-cycle flush-and-refetch pulse
//   fetch_misaligned            only with FETCH_MISALIGN_CHK_EN: misaligned redirect pulse
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirects halt fetch).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        decode_enable,
  output logic [31:0] i_din,
  output logic [31:0] fetch_pc,
  input  logic        decode_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;          // next PC to fetch (pending PC while flushing)
  logic [31:0] r_flush_addr;  // address of the request being discarded in FLUSH
  logic        r_out_vld;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_skid_vld;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic        w_consume;
  logic        w_ack_live;
  logic        w_to_out;
  logic        w_outstanding;
  logic        w_misalign;
  logic [31:0] w_redir_pc;

  assign w_consume     = r_out_vld & ~decode_stall;
  // Only a response to a live request in REQ carries usable data.
  assign w_ack_live    = imem_ack & (r_state == S_REQ);
  assign w_to_out      = w_ack_live & (~r_out_vld | w_consume) & ~r_skid_vld;
  assign w_outstanding = (r_state == S_REQ) | (r_state == S_FLUSH);
  assign w_redir_pc    = redirect_pc & ~32'h3;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misaligned;
  assign w_misalign       = |redirect_pc[1:0];
  assign fetch_misaligned = r_misaligned;
`else
  assign w_misalign = 1'b0;
`endif

  assign imem_req      = w_outstanding;
  // FLUSH keeps presenting the old address until its response is swallowed.
  assign imem_addr     = (r_state == S_FLUSH) ? r_flush_addr : r_pc;
  assign decode_enable = r_out_vld;
  assign i_din         = r_out_instr;
  assign fetch_pc      = r_out_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_flush_addr <= RESET_PC;
      r_out_vld    <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_out_pc     <= RESET_PC;
      r_skid_vld   <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHK_EN
      r_misaligned <= 1'b0;
`endif
      if (redirect_valid) begin
        // Redirect wins over stall and any same-cycle capture.
        r_out_vld   <= 1'b0;
        r_out_instr <= NOP_INSTR;
        r_skid_vld  <= 1'b0;
        r_pc        <= w_redir_pc;
        if (w_misalign) begin
`ifdef FETCH_MISALIGN_CHK_EN
          r_misaligned <= 1'b1;
`endif
          r_state <= S_HALT;
        end else if (w_outstanding && !imem_ack) begin
          // Keep the original in-flight address if already flushing.
          if (r_state == S_REQ) begin
            r_flush_addr <= r_pc;
          end
          r_state <= S_FLUSH;
        end else begin
          r_state <= S_REQ;
        end
      end else begin
        // Output register: new data, skid drain, or go empty.
        if (w_to_out) begin
          r_out_vld   <= 1'b1;
          r_out_instr <= imem_rdata;
          r_out_pc    <= r_pc;
        end else if (w_consume) begin
          if (r_skid_vld) begin
            r_out_vld   <= 1'b1;
            r_out_instr <= r_skid_instr;
            r_out_pc    <= r_skid_pc;
            r_skid_vld  <= 1'b0;
          end else begin
            r_out_vld   <= 1'b0;
            r_out_instr <= NOP_INSTR;
          end
        end

        if (w_ack_live) begin
          r_pc <= r_pc + 32'd4;
          if (!w_to_out) begin
            r_skid_vld   <= 1'b1;
            r_skid_instr <= imem_rdata;
            r_skid_pc    <= r_pc;
            r_state      <= S_HOLD;
          end
        end

        case (r_state)
          S_IDLE:  r_state <= S_REQ;
          S_HOLD:  if (w_consume) r_state <= S_REQ;
          S_FLUSH: if (imem_ack) r_state <= S_REQ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the memory returns addr ^ 32'h1234_0000 and acks
// combinationally whenever ack_en is set, so each step controls response timing.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        decode_enable;
  logic [31:0] i_din;
  logic [31:0] fetch_pc;
  logic        decode_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ack_en;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ 32'h1234_0000;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .decode_enable  (decode_enable),
    .i_din          (i_din),
    .fetch_pc       (fetch_pc),
    .decode_stall   (decode_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Sample outputs 1 time unit after the rising edge; inputs change right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    ack_en         = 1'b0;
    decode_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    // Reset values
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_de", decode_enable, 1'b0);
    chk("rst_din", i_din, 32'h0000_0013);
    chk("rst_pc", fetch_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk1("rst_mis", fetch_misaligned, 1'b0);
`endif

    // Zero-wait streaming
    rst_n  = 1'b1;
    ack_en = 1'b1;
    tick();
    chk1("s_req1", imem_req, 1'b1);
    chk("s_addr1", imem_addr, 32'h0);
    chk1("s_de1", decode_enable, 1'b0);
    tick();
    chk1("s_de0", decode_enable, 1'b1);
    chk("s_pc0", fetch_pc, 32'h0);
    chk("s_din0", i_din, 32'h1234_0000);
    tick();
    chk("s_pc4", fetch_pc, 32'h4);
    chk1("s_de4", decode_enable, 1'b1);
    tick();
    chk("s_pc8", fetch_pc, 32'h8);
    tick();
    chk("s_pcC", fetch_pc, 32'hC);
    chk("s_dinC", i_din, 32'h1234_000C);
    chk("s_addr10", imem_addr, 32'h10);

    // Slow memory: request for 0x10 waits, address held
    ack_en = 1'b0;
    tick();
    chk1("l_de_a", decode_enable, 1'b0);
    chk("l_din_nop", i_din, 32'h0000_0013);
    chk1("l_req_a", imem_req, 1'b1);
    chk("l_addr_a", imem_addr, 32'h10);
    tick();
    chk("l_addr_b", imem_addr, 32'h10);
    chk1("l_de_b", decode_enable, 1'b0);
    ack_en = 1'b1;
    tick();
    chk1("l_de_c", decode_enable, 1'b1);
    chk("l_pc10", fetch_pc, 32'h10);
    chk("l_din10", i_din, 32'h1234_0010);
    chk("l_addr14", imem_addr, 32'h14);

    // Stall with 0x14 in flight: response parks in skid, request drops
    ack_en       = 1'b0;
    decode_stall = 1'b1;
    tick();
    chk("st_pc1", fetch_pc, 32'h10);
    chk1("st_req1", imem_req, 1'b1);
    chk("st_addr1", imem_addr, 32'h14);
    ack_en = 1'b1;
    tick();
    chk("st_pc2", fetch_pc, 32'h10);
    chk1("st_de2", decode_enable, 1'b1);
    chk1("st_req2", imem_req, 1'b0);
    tick();
    chk1("st_req3", imem_req, 1'b0);
    tick();
    tick();
    chk("st_pc5", fetch_pc, 32'h10);
    chk("st_din5", i_din, 32'h1234_0010);
    chk1("st_req5", imem_req, 1'b0);
    decode_stall = 1'b0;
    tick();
    chk("st_pc14", fetch_pc, 32'h14);
    chk("st_din14", i_din, 32'h1234_0014);
    chk1("st_req6", imem_req, 1'b1);
    chk("st_addr18", imem_addr, 32'h18);
    tick();
    chk("st_pc18", fetch_pc, 32'h18);
    chk("st_din18", i_din, 32'h1234_0018);
    chk("st_addr1C", imem_addr, 32'h1C);

    // Redirect while 0x1C request pending (2-cycle latency) -> FLUSH
    ack_en = 1'b0;
    tick();
    chk1("fl_de0", decode_enable, 1'b0);
    chk("fl_addr0", imem_addr, 32'h1C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk1("fl_req", imem_req, 1'b1);
    chk("fl_addr_old", imem_addr, 32'h1C);
    chk1("fl_de1", decode_enable, 1'b0);
    ack_en = 1'b1;
    tick();
    chk1("fl_de2", decode_enable, 1'b0);
    chk("fl_addr100", imem_addr, 32'h100);
    tick();
    chk1("fl_de3", decode_enable, 1'b1);
    chk("fl_pc100", fetch_pc, 32'h100);
    chk("fl_din100", i_din, 32'h1234_0100);

    // Redirect with stall and same-cycle ack: data dropped
    decode_stall   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    decode_stall   = 1'b0;
    chk1("rs_de", decode_enable, 1'b0);
    chk("rs_din", i_din, 32'h0000_0013);
    chk("rs_addr", imem_addr, 32'h200);
    tick();
    chk("rs_pc200", fetch_pc, 32'h200);
    chk("rs_din200", i_din, 32'h1234_0200);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk1("ma_pulse", fetch_misaligned, 1'b1);
    chk1("ma_req0", imem_req, 1'b0);
    chk1("ma_de0", decode_enable, 1'b0);
    tick();
    chk1("ma_pulse_end", fetch_misaligned, 1'b0);
    chk1("ma_req1", imem_req, 1'b0);
    tick();
    chk1("ma_req2", imem_req, 1'b0);
    chk1("ma_de2", decode_enable, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk1("ma_req3", imem_req, 1'b1);
    chk("ma_addr200", imem_addr, 32'h200);
    chk1("ma_pulse3", fetch_misaligned, 1'b0);
    tick();
    chk1("ma_de4", decode_enable, 1'b1);
    chk("ma_pc200", fetch_pc, 32'h200);
`else
    chk("ma_addr100", imem_addr, 32'h100);
    chk1("ma_de0", decode_enable, 1'b0);
    tick();
    chk("ma_pc100", fetch_pc, 32'h100);
    chk("ma_din100", i_din, 32'h1234_0100);
`endif

    // PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("wr_din", i_din, 32'hEDCB_FFFC);
    chk("wr_addr0", imem_addr, 32'h0);
    tick();
    chk("wr_pc0", fetch_pc, 32'h0);
    chk("wr_din0", i_din, 32'h1234_0000);

    // Reset asserted with a request in flight
    ack_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk1("mr_req", imem_req, 1'b0);
    chk("mr_addr", imem_addr, 32'h0);
    chk1("mr_de", decode_enable, 1'b0);
    chk("mr_din", i_din, 32'h0000_0013);
    tick();
    ack_en = 1'b1;
    rst_n  = 1'b1;
    tick();
    chk1("mr_req1", imem_req, 1'b1);
    chk1("mr_de1", decode_enable, 1'b0);
    tick();
    chk1("mr_de2", decode_enable, 1'b1);
    chk("mr_pc2", fetch_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
